// File: rtl/nor_run_detector_pkg.sv
// Shared types and helpers for the NOR zero-run detector.
package nor_run_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } state_t;

    // Width needed to hold a run count from 0 up to run_len inclusive
    function automatic int RUN_W(input int run_len);
        if (run_len < 1) begin
            return 1;
        end else begin
            return $clog2(run_len + 1);
        end
    endfunction

endpackage

// File: rtl/nor_run_detector_if.sv
// Sample/control and status bundle between the NOR cell consumer and cache control.
interface nor_run_det_if
    import nor_run_det_pkg::*;
#(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) ();

    localparam int RW = RUN_W(RUN_LEN);

    logic             in_valid;
    logic             in_zero;
    logic             clr;
    logic [RW-1:0]    run_cnt;
    logic             active;
    logic             hit;
    logic [CNT_W-1:0] events;

    modport master (
        output in_valid, in_zero, clr,
        input  run_cnt, active, hit, events
    );

    modport slave (
        input  in_valid, in_zero, clr,
        output run_cnt, active, hit, events
    );

endinterface

// File: rtl/nor_run_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; never wraps past all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V = {W{1'b1}};

    logic [W-1:0] count_r;
    logic [W-1:0] count_s;

    // Next count: clear wins, otherwise increment until saturated
    always_comb begin
        count_s = count_r;
        if (clr) begin
            count_s = {W{1'b0}};
        end else if (inc && (count_r != MAX_V)) begin
            count_s = count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_s = count_r;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else begin
            count_r <= count_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/nor_run_detector.sv
// Detects runs of RUN_LEN consecutive valid all-zero samples and pulses hit once per run.
// Optional macro NOR_RUN_DET_RETRIGGER_EN: keep re-hitting every RUN_LEN zeros while in HIT.
module nor_run_detector
    import nor_run_det_pkg::*;
#(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    nor_run_det_if.slave bus
);

    localparam int RW = RUN_W(RUN_LEN);
    localparam logic [RW-1:0] CNT_ZERO  = {RW{1'b0}};
    localparam logic [RW-1:0] CNT_ONE   = RW'(1'b1);
    localparam logic [RW-1:0] RUN_LEN_V = RW'(RUN_LEN);

`ifdef NOR_RUN_DET_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    // With retrigger the count restarts on each hit so the next run can be measured
    localparam logic [RW-1:0] HIT_CNT = RETRIG ? CNT_ZERO : RUN_LEN_V;

    state_t           state_r;
    state_t           state_s;
    logic [RW-1:0]    run_cnt_r;
    logic [RW-1:0]    run_cnt_s;
    logic [RW-1:0]    cnt_inc_s;
    logic             hit_r;
    logic             hit_s;
    logic             active_r;
    logic [CNT_W-1:0] events_s;

    // Next-state, next run count and hit decision
    always_comb begin
        state_s   = state_r;
        run_cnt_s = run_cnt_r;
        hit_s     = 1'b0;
        cnt_inc_s = run_cnt_r + CNT_ONE;
        if (bus.clr) begin
            state_s   = IDLE;
            run_cnt_s = CNT_ZERO;
        end else if (bus.in_valid) begin
            case (state_r)
                IDLE: begin
                    if (bus.in_zero) begin
                        if (RUN_LEN_V == CNT_ONE) begin
                            state_s   = HIT;
                            run_cnt_s = HIT_CNT;
                            hit_s     = 1'b1;
                        end else begin
                            state_s   = RUN;
                            run_cnt_s = CNT_ONE;
                        end
                    end else begin
                        state_s   = IDLE;
                        run_cnt_s = CNT_ZERO;
                    end
                end
                RUN: begin
                    if (bus.in_zero) begin
                        if (cnt_inc_s == RUN_LEN_V) begin
                            state_s   = HIT;
                            run_cnt_s = HIT_CNT;
                            hit_s     = 1'b1;
                        end else begin
                            run_cnt_s = cnt_inc_s;
                        end
                    end else begin
                        state_s   = IDLE;
                        run_cnt_s = CNT_ZERO;
                    end
                end
                HIT: begin
                    if (!bus.in_zero) begin
                        state_s   = IDLE;
                        run_cnt_s = CNT_ZERO;
                    end else if (RETRIG) begin
                        if (cnt_inc_s == RUN_LEN_V) begin
                            run_cnt_s = CNT_ZERO;
                            hit_s     = 1'b1;
                        end else begin
                            run_cnt_s = cnt_inc_s;
                        end
                    end else begin
                        run_cnt_s = run_cnt_r;
                    end
                end
                default: begin
                    state_s   = IDLE;
                    run_cnt_s = CNT_ZERO;
                end
            endcase
        end else begin
            state_s   = state_r;
            run_cnt_s = run_cnt_r;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            run_cnt_r <= CNT_ZERO;
            hit_r     <= 1'b0;
            active_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            run_cnt_r <= run_cnt_s;
            hit_r     <= hit_s;
            active_r  <= (state_s == HIT);
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_events (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clr),
        .inc   (hit_s),
        .count (events_s)
    );

    assign bus.run_cnt = run_cnt_r;
    assign bus.active  = active_r;
    assign bus.hit     = hit_r;
    assign bus.events  = events_s;

endmodule

// File: tb/tb_nor_run_detector.sv
// Table-driven bench for nor_run_detector with RUN_LEN=4, CNT_W=3.
module tb_nor_run_detector;

    localparam int RUN_LEN = 4;
    localparam int CNT_W   = 3;

    typedef struct {
        string      name;
        logic       v;
        logic       z;
        logic       c;
        logic [2:0] rc;
        logic       act;
        logic       hit;
        logic [2:0] ev;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs[$];

    nor_run_det_if #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) bus ();

    nor_run_detector #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got %0d expected %0d", nm, idx, got, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int idx, input int rc, input int act,
                           input int hit, input int ev);
        chk({nm, ".run_cnt"}, idx, 8'(bus.run_cnt), 8'(rc));
        chk({nm, ".active"},  idx, 8'(bus.active),  8'(act));
        chk({nm, ".hit"},     idx, 8'(bus.hit),     8'(hit));
        chk({nm, ".events"},  idx, 8'(bus.events),  8'(ev));
    endtask

    function automatic void add(input string n, input logic v, input logic z, input logic c,
                                input int rc, input logic act, input logic hit, input int ev);
        vec_t r;
        r.name = n; r.v = v; r.z = z; r.c = c;
        r.rc = 3'(rc); r.act = act; r.hit = hit; r.ev = 3'(ev);
        vecs.push_back(r);
    endfunction

    task automatic step(input logic v, input logic z, input logic c);
        bus.in_valid = v;
        bus.in_zero  = z;
        bus.clr      = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_zero  = 1'b0;
        bus.clr      = 1'b0;

        // Expected sequences, one row per clock
        add("rst", 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 0);
        add("rst", 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 0);
        add("rst", 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 0);
        add("clr", 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 0);
        add("clr", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
        add("basic", 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 0);
        add("basic", 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 0);
        add("basic", 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 0);
        add("basic", 1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b1, 1);
        add("basic", 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1);
        add("basic", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1);
        add("abort", 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0);
        add("abort", 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 0);
        add("abort", 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 0);
        add("abort", 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 0);
        add("abort", 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 0);
        add("abort", 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 0);
        add("abort", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
        add("abort", 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 0);
        add("abort", 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 0);
        add("abort", 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 0);
        add("abort", 1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b1, 1);
        add("abort", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1);
        add("sat", 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0);
        for (int k = 1; k <= 9; k++) begin
            add("sat", 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, (k - 1 > 7) ? 7 : k - 1);
            add("sat", 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, (k - 1 > 7) ? 7 : k - 1);
            add("sat", 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, (k - 1 > 7) ? 7 : k - 1);
            add("sat", 1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b1, (k > 7) ? 7 : k);
            add("sat", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, (k > 7) ? 7 : k);
        end
        add("retrig", 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0);
        for (int i = 1; i <= 12; i++) begin
`ifdef NOR_RUN_DET_RETRIGGER_EN
            add("retrig", 1'b1, 1'b1, 1'b0, i % 4, i >= 4, (i % 4) == 0, i / 4);
`else
            add("retrig", 1'b1, 1'b1, 1'b0, (i < 4) ? i : 4, i >= 4, i == 4, (i >= 4) ? 1 : 0);
`endif
        end
`ifdef NOR_RUN_DET_RETRIGGER_EN
        add("retrig", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 3);
`else
        add("retrig", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1);
`endif

        // Reset held with toggling inputs
        for (int i = 0; i < 4; i++) begin
            step(i[0], ~i[0], i[1]);
            chk_all("in_reset", i, 0, 0, 0, 0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.clr      = 1'b0;
        rst_n        = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].z, vecs[i].c);
            chk_all(vecs[i].name, i, int'(vecs[i].rc), int'(vecs[i].act),
                    int'(vecs[i].hit), int'(vecs[i].ev));
        end

        // Async reset landing with the 4th zero: the pending hit must be lost
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk_all("arst_pre", 0, 3, 0, 0, 0);
        bus.in_valid = 1'b1;
        bus.in_zero  = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all("arst_now", 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_all("arst_hold", i, 0, 0, 0, 0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk_all("arst_post", 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
